integ_accum: RTL



---
 rtl/integ_pkg.sv | 32 +++
 rtl/byte_addsub.sv | 37 +++
 rtl/integ_accum.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/integ_pkg.sv
`default_nettype none
// ============================================================================
// Module   : integ_pkg
// Purpose  : Shared types and helpers for the integ_accum integrator.
//            - state_e       : controller states (IDLE, ADD, UPD)
//            - C_ACC_W_DEF   : default accumulator width
//            - sat_pos/neg   : two's-complement saturation limits for a width,
//                              returned as 32-bit patterns (caller slices)
// Revision : 1.0 - initial release
// ============================================================================
package integ_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    UPD  = 2'd2
  } state_e;

  localparam int C_ACC_W_DEF = 16;

  // Largest positive value representable in w bits: 2^(w-1) - 1
  function automatic logic [31:0] sat_pos(input int w);
    sat_pos = (32'h1 << (w - 1)) - 32'h1;
  endfunction

  // Most negative value in w bits: -2^(w-1), i.e. only the sign bit set
  function automatic logic [31:0] sat_neg(input int w);
    sat_neg = 32'h1 << (w - 1);
  endfunction

endpackage : integ_pkg
`default_nettype wire

// File: rtl/byte_addsub.sv
`default_nettype none
// ============================================================================
// Module   : byte_addsub
// Purpose  : One byte slice of the add/subtract datapath. Computes
//            a + (sub ? ~b : b) + cin as a 9-bit sum. Purely combinational;
//            the integrator time-multiplexes a single instance over all bytes.
// Ports    : a_i[7:0], b_i[7:0] - operand bytes
//            sub_i              - invert b_i (subtract when cin_i = 1)
//            cin_i              - carry in
//            s_o[7:0], cout_o   - sum byte and carry out
//            a_msb_o, bi_msb_o  - sign bits of the two adder operands
// Revision : 1.0 - initial release
// ============================================================================
module byte_addsub (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       sub_i,
  input  logic       cin_i,
  output logic [7:0] s_o,
  output logic       cout_o,
  output logic       a_msb_o,
  output logic       bi_msb_o
);

  logic [7:0] w_bi;
  logic [8:0] w_sum;

  assign w_bi  = sub_i ? ~b_i : b_i;
  assign w_sum = {1'b0, a_i} + {1'b0, w_bi} + {8'd0, cin_i};

  assign s_o      = w_sum[7:0];
  assign cout_o   = w_sum[8];
  assign a_msb_o  = a_i[7];
  assign bi_msb_o = w_bi[7];

endmodule : byte_addsub
`default_nettype wire

// File: rtl/integ_accum.sv
`default_nettype none
// ============================================================================
// Module   : integ_accum
// Purpose  : Multi-cycle signed integrator. Each strt adds (sub=0) or
//            subtracts (sub=1) a sign-extended 8-bit error sample to/from a
//            wide accumulator, one byte per cycle, then commits the result
//            and flags signed overflow (sticky).
// Ports    : clk, rst_n          - clock, synchronous active-low reset
//            strt_i, sub_i, err_i - start request, direction, error sample
//            clr_i                - zero integ/ov (IDLE only, beats strt)
//            busy_o, done_o       - op in progress, one-cycle completion pulse
//            integ_o, ov_o        - accumulator value, sticky overflow flag
// Config   : INTEG_SAT_EN - when defined, an overflowing result is clamped to
//            the signed limit instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module integ_accum
  import integ_pkg::*;
#(
  parameter int ACC_W = C_ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strt_i,
  input  logic             sub_i,
  input  logic [7:0]       err_i,
  input  logic             clr_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [ACC_W-1:0] integ_o,
  output logic             ov_o
);

  localparam int NBYTE = ACC_W / 8;
  localparam int KW    = (NBYTE > 1) ? $clog2(NBYTE) : 1;
  localparam logic [KW-1:0] C_K_LAST = KW'(NBYTE - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] a_q, a_d;       // working copy of integ, shifted down a byte per cycle
  logic [ACC_W-1:0] b_q, b_d;       // sign-extended err, shifted alongside a_q
  logic [ACC_W-1:0] res_q, res_d;   // result bytes shifted in from the top
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic             a_msb_q, a_msb_d;
  logic             bi_msb_q, bi_msb_d;
  logic [ACC_W-1:0] integ_q, integ_d;
  logic             ov_q, ov_d;
  logic             done_q, done_d;

  logic [7:0]       w_s;
  logic             w_cout;
  logic             w_a_msb;
  logic             w_bi_msb;
  logic             w_ovf;
  logic [ACC_W-1:0] w_upd_val;

  // Operands are always presented from byte 0 because a_q/b_q shift right
  byte_addsub u_byte_addsub (
    .a_i      (a_q[7:0]),
    .b_i      (b_q[7:0]),
    .sub_i    (sub_q),
    .cin_i    (carry_q),
    .s_o      (w_s),
    .cout_o   (w_cout),
    .a_msb_o  (w_a_msb),
    .bi_msb_o (w_bi_msb)
  );

  // Signed overflow: operands agree in sign but the result does not
  assign w_ovf = (a_msb_q == bi_msb_q) && (res_q[ACC_W-1] != a_msb_q);

`ifdef INTEG_SAT_EN
  logic [31:0] w_pos_lim;
  logic [31:0] w_neg_lim;

  assign w_pos_lim = sat_pos(ACC_W);
  assign w_neg_lim = sat_neg(ACC_W);
  // Both operands share a_msb on overflow, so it selects the clamp direction
  assign w_upd_val = !w_ovf  ? res_q :
                     a_msb_q ? w_neg_lim[ACC_W-1:0] : w_pos_lim[ACC_W-1:0];
`else
  assign w_upd_val = res_q;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    k_d      = k_q;
    a_msb_d  = a_msb_q;
    bi_msb_d = bi_msb_q;
    integ_d  = integ_q;
    ov_d     = ov_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (clr_i) begin
          integ_d = '0;
          ov_d    = 1'b0;
        end else if (strt_i) begin
          a_d     = integ_q;
          b_d     = {{(ACC_W-8){err_i[7]}}, err_i};
          sub_d   = sub_i;
          carry_d = sub_i;   // +1 completes the two's-complement negate
          k_d     = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        a_d     = a_q >> 8;
        b_d     = b_q >> 8;
        res_d   = {w_s, res_q[ACC_W-1:8]};
        carry_d = w_cout;
        k_d     = k_q + 1'b1;
        if (k_q == C_K_LAST) begin
          a_msb_d  = w_a_msb;
          bi_msb_d = w_bi_msb;
          state_d  = UPD;
        end
      end
      UPD: begin
        integ_d = w_upd_val;
        if (w_ovf) begin
          ov_d = 1'b1;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      k_q      <= '0;
      a_msb_q  <= 1'b0;
      bi_msb_q <= 1'b0;
      integ_q  <= '0;
      ov_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      k_q      <= k_d;
      a_msb_q  <= a_msb_d;
      bi_msb_q <= bi_msb_d;
      integ_q  <= integ_d;
      ov_q     <= ov_d;
      done_q   <= done_d;
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;
  assign integ_o = integ_q;
  assign ov_o    = ov_q;

endmodule : integ_accum
`default_nettype wire
